// File: rtl/uart_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_bridge
// Desc     : TX/RX byte FIFOs between the CPU register port and the UART pair.
//            Optional RTS flow control is built when UART_RTS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_bridge #(
  parameter int TXDEPTH_LOG2 = 4,
  parameter int RXDEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_wr,
  input  logic       ctrl_wr,
  input  logic       data_rd,
  output logic [7:0] data_out,
  output logic [7:0] status,
  output logic [7:0] txdata,
  output logic       txbegin,
  input  logic       txbusy,
  input  logic [7:0] rxdata,
  input  logic       rxrecv,
  output logic       rts_n
);

  localparam int c_tx_depth = 1 << TXDEPTH_LOG2;
  localparam int c_rx_depth = 1 << RXDEPTH_LOG2;
  localparam logic [TXDEPTH_LOG2:0] c_tx_full_cnt = {1'b1, {TXDEPTH_LOG2{1'b0}}};
  localparam logic [RXDEPTH_LOG2:0] c_rx_full_cnt = {1'b1, {RXDEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    T_IDLE     = 2'd0,
    T_PULSE    = 2'd1,
    T_WAITBUSY = 2'd2,
    T_WAITDONE = 2'd3
  } tx_state_t;

  logic w_flush;
  logic w_ovf_clr;
  assign w_flush   = ctrl_wr & data_in[1];
  assign w_ovf_clr = ctrl_wr & data_in[0];

  // ---------------- TX FIFO and transmitter handshake ----------------
  logic [7:0]            r_tx_mem [c_tx_depth];
  logic [TXDEPTH_LOG2:0] r_tx_wptr;
  logic [TXDEPTH_LOG2:0] r_tx_rptr;
  logic [TXDEPTH_LOG2:0] w_tx_count;
  logic                  w_tx_empty;
  logic                  w_tx_full;
  logic                  w_tx_push;
  logic                  w_tx_pop;
  logic                  w_tx_idle;
  tx_state_t             r_tx_state;

  assign w_tx_count = r_tx_wptr - r_tx_rptr;
  assign w_tx_empty = (w_tx_count == '0);
  assign w_tx_full  = (w_tx_count == c_tx_full_cnt);
  assign w_tx_push  = data_wr & ~w_tx_full;
  assign w_tx_pop   = (r_tx_state == T_IDLE) & ~w_tx_empty & ~txbusy;
  assign w_tx_idle  = w_tx_empty & (r_tx_state == T_IDLE) & ~txbusy;

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr[TXDEPTH_LOG2-1:0]] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
      // Flush drops everything queued; a byte written in the same cycle survives.
      if (w_flush)       r_tx_rptr <= r_tx_wptr;
      else if (w_tx_pop) r_tx_rptr <= r_tx_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= T_IDLE;
      txbegin    <= 1'b0;
      txdata     <= 8'h00;
    end else begin
      txbegin <= 1'b0;
      case (r_tx_state)
        T_IDLE: begin
          if (w_tx_pop) begin
            txdata     <= r_tx_mem[r_tx_rptr[TXDEPTH_LOG2-1:0]];
            txbegin    <= 1'b1;
            r_tx_state <= T_PULSE;
          end
        end
        T_PULSE:    r_tx_state <= T_WAITBUSY;
        T_WAITBUSY: if (txbusy)  r_tx_state <= T_WAITDONE;
        T_WAITDONE: if (!txbusy) r_tx_state <= T_IDLE;
        default:    r_tx_state <= T_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]            r_rx_mem [c_rx_depth];
  logic [RXDEPTH_LOG2:0] r_rx_wptr;
  logic [RXDEPTH_LOG2:0] r_rx_rptr;
  logic [RXDEPTH_LOG2:0] w_rx_count;
  logic                  r_rxrecv_d;
  logic                  r_rx_ovf;
  logic                  w_rx_empty;
  logic                  w_rx_full;
  logic                  w_rx_rise;
  logic                  w_rx_pop;
  logic                  w_rx_push;
  logic                  w_rx_ovf_set;

  assign w_rx_count   = r_rx_wptr - r_rx_rptr;
  assign w_rx_empty   = (w_rx_count == '0);
  assign w_rx_full    = (w_rx_count == c_rx_full_cnt);
  assign w_rx_rise    = rxrecv & ~r_rxrecv_d;
  assign w_rx_pop     = data_rd & ~w_rx_empty;
  // A read in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign w_rx_push    = w_rx_rise & ~w_flush & (~w_rx_full | w_rx_pop);
  assign w_rx_ovf_set = w_rx_rise & ~w_flush & w_rx_full & ~w_rx_pop;

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr[RXDEPTH_LOG2-1:0]] <= rxdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rxrecv_d <= 1'b0;
      r_rx_ovf   <= 1'b0;
    end else begin
      r_rxrecv_d <= rxrecv;
      if (w_flush) begin
        r_rx_rptr <= r_rx_wptr;
      end else begin
        if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
        if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
      end
      if (w_rx_ovf_set)   r_rx_ovf <= 1'b1;
      else if (w_ovf_clr) r_rx_ovf <= 1'b0;
    end
  end

  assign data_out = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rptr[RXDEPTH_LOG2-1:0]];
  assign status   = {~w_rx_empty, w_tx_full, r_rx_ovf, w_tx_idle, 4'b0000};

`ifdef UART_RTS_EN
  localparam logic [RXDEPTH_LOG2:0] c_rts_hi = c_rx_full_cnt - 2'd2;
  localparam logic [RXDEPTH_LOG2:0] c_rts_lo = c_rx_full_cnt >> 1;
  logic r_rts_n;

  // Hysteresis: assert near full, release only once half drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_rts_n <= 1'b0;
    else if (w_rx_count >= c_rts_hi) r_rts_n <= 1'b1;
    else if (w_rx_count <= c_rts_lo) r_rts_n <= 1'b0;
  end

  assign rts_n = r_rts_n;
`else
  assign rts_n = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_fifo_bridge
// Desc     : Self-checking bench for uart_fifo_bridge with a transmitter model
//            and a queue-based reference model. Honours UART_RTS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_fifo_bridge;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_wr = 1'b0;
  logic       ctrl_wr = 1'b0;
  logic       data_rd = 1'b0;
  logic [7:0] data_out;
  logic [7:0] status;
  logic [7:0] txdata;
  logic       txbegin;
  logic       txbusy = 1'b0;
  logic [7:0] rxdata = 8'h00;
  logic       rxrecv = 1'b0;
  logic       rts_n;

  uart_fifo_bridge dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .data_wr  (data_wr),
    .ctrl_wr  (ctrl_wr),
    .data_rd  (data_rd),
    .data_out (data_out),
    .status   (status),
    .txdata   (txdata),
    .txbegin  (txbegin),
    .txbusy   (txbusy),
    .rxdata   (rxdata),
    .rxrecv   (rxrecv),
    .rts_n    (rts_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transmitter model: busy starts the cycle after txbegin drops, lasts busy_len cycles.
  int         busy_len = 607;
  int         busy_cnt = 0;
  int         n_begin = 0;
  logic       model_busy = 1'b0;
  logic       force_busy = 1'b0;
  logic       start_pending = 1'b0;
  logic       lag = 1'b0;
  logic       prev_tb = 1'b0;
  logic [7:0] sent_q[$];

  task automatic xmit();
    lag = 1'b0;
    if (txbegin) begin
      check("txbegin_width", {31'd0, prev_tb}, 32'd0);
      if (!prev_tb) begin
        n_begin++;
        sent_q.push_back(txdata);
      end
      start_pending = 1'b1;
    end else if (start_pending) begin
      start_pending = 1'b0;
      model_busy    = 1'b1;
      busy_cnt      = busy_len;
    end else if (model_busy) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        model_busy = 1'b0;
        lag        = 1'b1;
      end
    end
    prev_tb = txbegin;
    txbusy  = model_busy | force_busy;
  endtask

  function automatic logic in_flight();
    return start_pending | model_busy | lag | txbegin;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    xmit();
    #1;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rxdata = b;
    rxrecv = 1'b1;
    step();
    rxrecv = 1'b0;
    step();
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       cw;
    logic       rd;
    logic       rx;
    logic [7:0] rxd;
    logic [7:0] exp_do;
    logic [7:0] exp_st;
  } vec_t;

  vec_t tbl[12];

  // Reference model state for the randomized phase
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       ovf_m, prev_rx, flushing, have_fh, edge_m, ovf_set_m;
  logic       t_wr, t_rd, t_cw, t_rx;
  logic [7:0] t_din, t_rxd, fh, exp_tx, exp_st, exp_do;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 8'h11, 8'h90};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h22, 8'h11, 8'h90};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11, 8'h90};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h33, 8'h11, 8'h90};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h33, 8'h90};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h44, 8'h44, 8'h90};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h10};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h10};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h55, 8'h55, 8'h90};
    tbl[9]  = '{1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h10};
    tbl[10] = '{1'b0, 8'h02, 1'b1, 1'b0, 1'b1, 8'h66, 8'h00, 8'h10};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h10};

    // Reset state
    step();
    step();
    check("rst_data_out", {24'd0, data_out}, 32'h00);
    check("rst_status", {24'd0, status}, 32'h10);
    check("rst_txbegin", {31'd0, txbegin}, 32'd0);
    check("rst_txdata", {24'd0, txdata}, 32'h00);
    check("rst_rts_n", {31'd0, rts_n}, 32'd0);
    rst_n = 1'b1;
    step();

    // Table-driven RX / control vectors
    for (int i = 0; i < 12; i++) begin
      data_wr = tbl[i].wr;
      data_in = tbl[i].din;
      ctrl_wr = tbl[i].cw;
      data_rd = tbl[i].rd;
      rxrecv  = tbl[i].rx;
      rxdata  = tbl[i].rxd;
      step();
      check($sformatf("vec%0d_data_out", i), {24'd0, data_out}, {24'd0, tbl[i].exp_do});
      check($sformatf("vec%0d_status", i), {24'd0, status}, {24'd0, tbl[i].exp_st});
    end
    data_wr = 1'b0; ctrl_wr = 1'b0; data_rd = 1'b0; rxrecv = 1'b0; data_in = 8'h00;
    step();

    // Two bytes through a slow transmitter
    busy_len = 607; n_begin = 0; sent_q.delete();
    data_in = 8'h41; data_wr = 1'b1; step();
    data_in = 8'h42; step();
    data_wr = 1'b0;
    for (int k = 0; k < 3000 && !(n_begin == 2 && !model_busy && !start_pending); k++) step();
    check("tx1_begin_count", n_begin, 2);
    check("tx1_byte0", sent_q.size() > 0 ? {24'd0, sent_q[0]} : 32'hFFFF, 32'h41);
    check("tx1_byte1", sent_q.size() > 1 ? {24'd0, sent_q[1]} : 32'hFFFF, 32'h42);
    check("tx1_not_idle_yet", {31'd0, status[4]}, 32'd0);
    step();
    check("tx1_idle", {24'd0, status}, 32'h10);
    check("tx1_txdata_held", {24'd0, txdata}, 32'h42);

    // TX full with transmitter held busy
    busy_len = 20; n_begin = 0; sent_q.delete();
    force_busy = 1'b1; txbusy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      data_in = 8'(i); data_wr = 1'b1; step();
      if (i == 14) check("tx_full_after15", {31'd0, status[6]}, 32'd0);
      if (i >= 15) check($sformatf("tx_full_after%0d", i + 1), {31'd0, status[6]}, 32'd1);
    end
    data_wr = 1'b0;
    check("tx_held_no_begin", n_begin, 0);
    force_busy = 1'b0;
    for (int k = 0; k < 1000 && !(n_begin == 16 && !in_flight()); k++) step();
    for (int k = 0; k < 5; k++) step();
    check("tx_drain_count", n_begin, 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("tx_drain_byte%0d", i), i < sent_q.size() ? {24'd0, sent_q[i]} : 32'hFFFF, i);
    check("tx_drain_idle", {24'd0, status}, 32'h10);

    // RX overflow and ordered readout
    for (int i = 0; i < 17; i++) begin
      rx_pulse(8'hA0 + 8'(i));
      if (i == 15) check("rx_no_ovf_at16", {31'd0, status[5]}, 32'd0);
    end
    check("rx_ovf_set", {31'd0, status[5]}, 32'd1);
    check("rx_not_empty", {31'd0, status[7]}, 32'd1);
    check("rx_head_A0", {24'd0, data_out}, 32'hA0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("rx_read%0d", i), {24'd0, data_out}, 32'hA0 + i);
      data_rd = 1'b1; step(); data_rd = 1'b0;
    end
    check("rx_empty_data", {24'd0, data_out}, 32'h00);
    check("rx_empty_flag", {31'd0, status[7]}, 32'd0);

    // Push and read together on a full FIFO
    data_in = 8'h01; ctrl_wr = 1'b1; step(); ctrl_wr = 1'b0;
    check("ovf_cleared", {31'd0, status[5]}, 32'd0);
    for (int i = 0; i < 16; i++) rx_pulse(8'hC0 + 8'(i));
    check("full_head", {24'd0, data_out}, 32'hC0);
    rxdata = 8'hEE; rxrecv = 1'b1; data_rd = 1'b1; step();
    rxrecv = 1'b0; data_rd = 1'b0;
    check("full_pushrd_ovf", {31'd0, status[5]}, 32'd0);
    check("full_pushrd_head", {24'd0, data_out}, 32'hC1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("full_pushrd_read%0d", i), {24'd0, data_out}, i < 15 ? 32'hC1 + i : 32'hEE);
      data_rd = 1'b1; step(); data_rd = 1'b0;
    end
    check("full_pushrd_empty", {31'd0, status[7]}, 32'd0);

    // Overflow set beats clear; then flush both FIFOs with a byte in flight
    for (int i = 0; i < 16; i++) rx_pulse(8'h10 + 8'(i));
    rxdata = 8'h99; rxrecv = 1'b1; ctrl_wr = 1'b1; data_in = 8'h01; step();
    rxrecv = 1'b0; ctrl_wr = 1'b0;
    check("ovf_set_wins", {31'd0, status[5]}, 32'd1);
    busy_len = 30; n_begin = 0; sent_q.delete();
    data_wr = 1'b1;
    data_in = 8'hC1; step();
    data_in = 8'hC2; step();
    data_in = 8'hC3; step();
    data_wr = 1'b0;
    data_in = 8'h03; ctrl_wr = 1'b1; step(); ctrl_wr = 1'b0;
    check("flush_rx_empty", {31'd0, status[7]}, 32'd0);
    check("flush_data_out", {24'd0, data_out}, 32'h00);
    check("flush_ovf_clr", {31'd0, status[5]}, 32'd0);
    for (int k = 0; k < 200 && status != 8'h10; k++) step();
    check("flush_status_idle", {24'd0, status}, 32'h10);
    check("flush_inflight_only", n_begin, 1);
    check("flush_inflight_byte", sent_q.size() > 0 ? {24'd0, sent_q[0]} : 32'hFFFF, 32'hC1);

    // Reset during T_WAITDONE
    busy_len = 50; n_begin = 0; sent_q.delete();
    data_in = 8'hD1; data_wr = 1'b1; step(); data_wr = 1'b0;
    for (int k = 0; k < 20 && !model_busy; k++) step();
    check("rst_mid_busy_seen", {31'd0, model_busy}, 32'd1);
    step(); step();
    rst_n = 1'b0;
    #1;
    check("rst_mid_txbegin", {31'd0, txbegin}, 32'd0);
    check("rst_mid_txdata", {24'd0, txdata}, 32'h00);
    check("rst_mid_status", {24'd0, status}, 32'h00);
    step();
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 100 && model_busy; k++) step();
    for (int k = 0; k < 5; k++) step();
    check("rst_mid_no_new_begin", n_begin, 1);
    data_in = 8'hE5; data_wr = 1'b1; step(); data_wr = 1'b0;
    for (int k = 0; k < 20 && n_begin < 2; k++) step();
    check("rst_mid_next_byte", sent_q.size() > 1 ? {24'd0, sent_q[1]} : 32'hFFFF, 32'hE5);
    for (int k = 0; k < 200 && status != 8'h10; k++) step();
    check("rst_mid_idle", {24'd0, status}, 32'h10);

`ifdef UART_RTS_EN
    for (int i = 0; i < 13; i++) rx_pulse(8'(i));
    check("rts_at13", {31'd0, rts_n}, 32'd0);
    rx_pulse(8'h0D);
    check("rts_at14", {31'd0, rts_n}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      data_rd = 1'b1; step(); data_rd = 1'b0; step();
      if (k == 4) check("rts_hold_at9", {31'd0, rts_n}, 32'd1);
    end
    check("rts_release_at8", {31'd0, rts_n}, 32'd0);
`else
    for (int i = 0; i < 15; i++) rx_pulse(8'(i));
    check("rts_tied_low", {31'd0, rts_n}, 32'd0);
`endif

    // Randomized traffic against the queue model
    data_in = 8'h03; ctrl_wr = 1'b1; step(); ctrl_wr = 1'b0;
    busy_len = 3;
    for (int k = 0; k < 200 && status != 8'h10; k++) step();
    check("rand_start_idle", {24'd0, status}, 32'h10);
    tx_q.delete(); rx_q.delete();
    ovf_m = 1'b0; prev_rx = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      t_wr  = ($urandom_range(0, 2) == 0);
      t_din = 8'($urandom);
      t_rd  = ($urandom_range(0, (cyc < 1000) ? 5 : 1) == 0);
      t_rx  = 1'($urandom);
      t_rxd = 8'($urandom);
      t_cw  = ($urandom_range(0, 63) == 0);
      if (t_cw) begin
        t_wr  = 1'b0;
        t_din = 8'($urandom_range(0, 3));
        if (t_din[1]) t_rx = prev_rx;
      end
      flushing = t_cw & t_din[1];
      have_fh  = 1'b0;
      fh       = 8'h00;
      if (flushing) begin
        have_fh = (tx_q.size() > 0);
        if (have_fh) fh = tx_q[0];
        tx_q.delete();
      end
      if (t_wr && tx_q.size() < 16) tx_q.push_back(t_din);
      edge_m    = t_rx & ~prev_rx;
      ovf_set_m = 1'b0;
      if (flushing) rx_q.delete();
      else begin
        if (t_rd && rx_q.size() > 0) void'(rx_q.pop_front());
        if (edge_m) begin
          if (rx_q.size() < 16) rx_q.push_back(t_rxd);
          else ovf_set_m = 1'b1;
        end
      end
      if (ovf_set_m) ovf_m = 1'b1;
      else if (t_cw && t_din[0]) ovf_m = 1'b0;
      prev_rx = t_rx;

      data_wr = t_wr; data_in = t_din; data_rd = t_rd;
      ctrl_wr = t_cw; rxrecv = t_rx; rxdata = t_rxd;
      step();

      if (txbegin) begin
        if (flushing && have_fh) check("rand_txdata_flush", {24'd0, txdata}, {24'd0, fh});
        else if (tx_q.size() > 0) begin
          exp_tx = tx_q.pop_front();
          check("rand_txdata", {24'd0, txdata}, {24'd0, exp_tx});
        end else check("rand_tx_spurious", {31'd0, txbegin}, 32'd0);
      end
      exp_do = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
      exp_st = {rx_q.size() > 0, tx_q.size() == 16, ovf_m,
                (tx_q.size() == 0) && !in_flight() && !txbusy, 4'b0000};
      check("rand_data_out", {24'd0, data_out}, {24'd0, exp_do});
      check("rand_status", {24'd0, status}, {24'd0, exp_st});
    end
    data_wr = 1'b0; data_rd = 1'b0; ctrl_wr = 1'b0; rxrecv = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
